multi_tick_gen: RTL and testbench
=================================

# multi_tick_gen

Multi-channel programmable clock-enable generator; next generation of the single fixed-divisor enable block. Each of NUM_CH channels produces a one-cycle enable pulse every (div+1) clk_in cycles, with a runtime-loaded divisor, periodic or one-shot mode, per-channel run control and a global phase-align input. It feeds the PWM, sensor-sampling and PID-update loops so that all of them can share one clock domain.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 16: divisor and counter width in bits.
- RESET_DIV, 0: active divisor of every channel after reset; must fit in CNT_W.
- clk_in  in  1  system clock; all state changes on the rising edge.
- reset_in  in  1  reset, asynchronous and active-high.
- cfg_we  in  1  divisor/mode write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; a write to an index >= NUM_CH is ignored.
- cfg_div  in  CNT_W  new divisor; the period is cfg_div+1 cycles.
- cfg_oneshot  in  1  new mode: 1 = one-shot, 0 = periodic.
- ch_run  in  NUM_CH  per-channel level run request.
- sync  in  1  global phase align; restarts every counting channel.
- tick_en  out  NUM_CH  registered enable pulses.
- ch_busy  out  NUM_CH  1 while a channel is in ST_COUNT.

## Operation
- Each channel holds the following state:
  - state: ST_IDLE, ST_COUNT or ST_DONE.
  - cnt, CNT_W bits.
  - active div and mode.
  - pending div and mode, plus a pend_valid flag.
- Reset:
  - state = ST_IDLE, cnt = 0.
  - active div = RESET_DIV, mode = periodic, pend_valid = 0.
  - tick_en = 0, ch_busy = 0.
- ST_IDLE:
  - If ch_run = 1, go to ST_COUNT with cnt = 0 (the arming edge).
- ST_COUNT, priority order:
  - ch_run = 0: go to ST_IDLE, cnt = 0, tick = 0.
  - Else sync = 1: cnt = 0, tick = 0.
  - Else cnt == active div: this is a wrap. Set cnt = 0 and tick = 1. If mode is one-shot, go to ST_DONE.
  - Else cnt = cnt + 1, tick = 0.
- ST_DONE:
  - The one-shot has completed; tick = 0.
  - When ch_run = 0, go to ST_IDLE. The channel re-arms only on a fresh ch_run assertion.
- Configuration write to a channel in ST_COUNT:
  - pending = {cfg_div, cfg_oneshot}, pend_valid = 1.
  - At the next wrap, including a wrap on the same edge as the write, active = pending and pend_valid = 0.
  - The wrap compare on that edge uses the old active div. The mode used for the ST_DONE decision at that wrap is the new mode.
  - A later write before the wrap overwrites pending.
- Configuration write to a channel in ST_IDLE or ST_DONE: active is updated on the same edge.
- sync has no effect on channels in ST_IDLE or ST_DONE. An IDLE channel that arms on a sync edge arms normally with cnt = 0.
- div = 0 in periodic mode: tick_en is held at 1 from the first edge after the arming edge.

## Timing
- First tick: tick_en rises div+1 edges after the arming edge and stays high for exactly 1 cycle.
- Periodic spacing between ticks: exactly div+1 cycles.
- After sync: the next tick comes div+1 edges after the sync edge, so channels with equal div become phase-aligned.
- ch_busy is registered: 1 from the cycle after the arming edge, 0 from the cycle after leaving ST_COUNT.
- tick_en and ch_busy are pure register outputs, with no combinational path from any input.
- Reset asserted mid-count clears every output asynchronously. After reset deassertion, each channel re-arms from ST_IDLE once it sees ch_run high.
- The counter never exceeds active div.
- A running-channel write with a div below the current cnt is safe, because the old div governs until the wrap.

## Structure
- Package tick_pkg holds:
  - tick_state_e {ST_IDLE, ST_COUNT, ST_DONE}.
  - localparam MAX_CH = 16.
  - Typedef ch_cfg_t {div, oneshot}, parameterised through a CNT_W-sized logic in the module.
- Sub-module tick_channel is one channel: FSM, counter, active and pending registers. Its inputs are:
  - clk_in, reset_in.
  - run, sync.
  - cfg_we (decoded), cfg_div, cfg_oneshot.
- multi_tick_gen decodes cfg_ch, instantiates NUM_CH tick_channel blocks in a generate loop, and concatenates their outputs.

## Test plan
- Periodic period: ch0, div = 3, ch_run[0] = 1 held → tick_en[0] pulses 4, 8 and 12 edges after arming, each 1 cycle wide; ch_busy[0] = 1.
- Runtime reload: ch1 running with div = 9; write div = 2 at cnt = 5 → the next tick stays at cnt = 9, then ticks follow every 3 cycles.
- One-shot: ch2 configured div = 4 with oneshot = 1; raise ch_run → a single tick after 5 edges, ch_busy falls, then no further ticks. Drop ch_run and raise it again → one more tick.
- Sync alignment: ch0 div = 7 and ch3 div = 7, armed 3 cycles apart; pulse sync → both ticks coincide 8 edges after sync. A sync landing on a wrap edge suppresses that tick.
- Stop and reset: deassert ch_run on a wrap edge → no tick and ch_busy drops. Assert reset_in mid-count → tick_en = 0 and ch_busy = 0 immediately, and active div returns to RESET_DIV.
- Edge cases: div = 0 periodic → tick_en held high. div = 2^CNT_W−1 → period 2^CNT_W. Write with cfg_ch >= NUM_CH → no channel changes.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types for the multi-channel clock-enable generator.
package tick_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DONE} tick_state_e;
  localparam int MAX_CH = 16;
endpackage

// File: rtl/tick_channel.sv
// One enable channel: run/arm FSM, wrap counter, active and pending divisor/mode.
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             run,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic             tick,
  output logic             busy
);
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic             oneshot;
  } ch_cfg_t;

  tick_state_e      state;
  logic [CNT_W-1:0] cnt;
  ch_cfg_t          act, pend, wr_cfg, wrap_cfg;
  logic             pend_valid;

  assign wr_cfg = {cfg_div, cfg_oneshot};
  // A write landing on the wrap edge takes effect at that wrap; compare still uses old div.
  assign wrap_cfg = cfg_we ? wr_cfg : (pend_valid ? pend : act);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      act        <= {CNT_W'(RESET_DIV), 1'b0};
      pend       <= '0;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cfg_we && state != ST_COUNT) begin
        act        <= wr_cfg;
        pend_valid <= 1'b0;
      end
      case (state)
        ST_COUNT: begin
          if (cfg_we) begin
            pend       <= wr_cfg;
            pend_valid <= 1'b1;
          end
          if (!run) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (sync) begin
            cnt <= '0;
          end else if (cnt == act.div) begin
            cnt        <= '0;
            tick       <= 1'b1;
            act        <= wrap_cfg;
            pend_valid <= 1'b0;
            if (wrap_cfg.oneshot) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!run) state <= ST_IDLE;
        end
        default: begin
          if (run) begin
            state <= ST_COUNT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable clock-enable generator: decodes config writes to NUM_CH channels.
module multi_tick_gen
  import tick_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_run,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick_en,
  output logic [NUM_CH-1:0] ch_busy
);
  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range indices match no channel, so such writes are dropped.
    assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W    (CNT_W),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .run        (ch_run[i]),
      .sync       (sync),
      .cfg_we     (ch_we[i]),
      .cfg_div    (cfg_div),
      .cfg_oneshot(cfg_oneshot),
      .tick       (tick_en[i]),
      .busy       (ch_busy[i])
    );
  end
endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen with hand-computed tick positions.
module tb_multi_tick_gen;
  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       cfg_we, cfg_we3, cfg_oneshot, sync;
  logic [1:0] cfg_ch, cfg_ch3;
  logic [7:0] cfg_div;
  logic [3:0] ch_run, tick_en, ch_busy;
  logic [2:0] ch_run3, tick_en3, ch_busy3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  multi_tick_gen #(.NUM_CH(4), .CNT_W(8), .RESET_DIV(5)) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .ch_run(ch_run), .sync(sync),
    .tick_en(tick_en), .ch_busy(ch_busy)
  );

  // Three-channel instance so that cfg_ch = 3 is an out-of-range index.
  multi_tick_gen #(.NUM_CH(3), .CNT_W(8), .RESET_DIV(5)) u_dut3 (
    .clk_in(clk_in), .reset_in(reset_in), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .ch_run(ch_run3), .sync(sync),
    .tick_en(tick_en3), .ch_busy(ch_busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int ch, input int div, input logic os);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(div); cfg_oneshot = os;
    cyc1;
    cfg_we = 1'b0;
  endtask

  logic [31:0] obs, obs2, early, last;
  int n, t1, t2;

  initial begin
    reset_in = 1'b1; cfg_we = 0; cfg_we3 = 0; cfg_ch = 0; cfg_ch3 = 0; cfg_div = 0;
    cfg_oneshot = 0; ch_run = 0; ch_run3 = 0; sync = 0;
    repeat (3) cyc1;
    chk("rst_tick", 32'(tick_en), 0);
    chk("rst_busy", 32'(ch_busy), 0);
    reset_in = 1'b0;
    cyc1;

    // RESET_DIV = 5 governs a channel that was never written: ticks every 6 edges
    ch_run[1] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 12; k++) begin cyc1; obs[k-1] = tick_en[1]; end
    chk("rstdiv_ticks", obs, 32'h820);
    ch_run[1] = 1'b0; cyc1;
    chk("rstdiv_busy_off", 32'(ch_busy[1]), 0);

    // periodic div 3: ticks at 4, 8, 12
    wr(0, 3, 0);
    ch_run[0] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 12; k++) begin cyc1; obs[k-1] = tick_en[0]; end
    chk("per_ticks", obs, 32'h888);
    chk("per_busy", 32'(ch_busy[0]), 1);
    ch_run[0] = 1'b0; cyc1;

    // reload 9 -> 2 at cnt 5: ticks at 10, 13, 16
    wr(1, 9, 0);
    ch_run[1] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 16; k++) begin
      cfg_we = (k == 6); cfg_ch = 2'd1; cfg_div = 8'd2; cfg_oneshot = 1'b0;
      cyc1;
      obs[k-1] = tick_en[1];
    end
    cfg_we = 1'b0;
    chk("reload_ticks", obs, 32'h9200);
    ch_run[1] = 1'b0; cyc1;

    // one-shot div 4: single tick at 5, re-arm gives one more
    wr(2, 4, 1);
    ch_run[2] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc1; obs[k-1] = tick_en[2];
      if (k == 4) chk("os_busy_run", 32'(ch_busy[2]), 1);
    end
    chk("os_ticks", obs, 32'h010);
    chk("os_busy_done", 32'(ch_busy[2]), 0);
    ch_run[2] = 1'b0; cyc1;
    ch_run[2] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 6; k++) begin cyc1; obs[k-1] = tick_en[2]; end
    chk("os_rearm", obs, 32'h10);
    ch_run[2] = 1'b0; cyc1;

    // sync aligns ch0/ch3; a sync on a wrap edge suppresses that tick
    wr(0, 7, 0); wr(3, 7, 0);
    ch_run[0] = 1'b1; cyc1; cyc1; cyc1;
    ch_run[3] = 1'b1; cyc1; cyc1;
    sync = 1'b1; cyc1; sync = 1'b0;
    obs = 0; obs2 = 0;
    for (int k = 1; k <= 8; k++) begin cyc1; obs[k-1] = tick_en[0]; obs2[k-1] = tick_en[3]; end
    chk("sync_ch0", obs, 32'h80);
    chk("sync_ch3", obs2, 32'h80);
    obs = 0; obs2 = 0;
    for (int k = 1; k <= 16; k++) begin
      sync = (k == 8); cyc1;
      obs[k-1] = tick_en[0]; obs2[k-1] = tick_en[3];
    end
    sync = 1'b0;
    chk("syncwrap_ch0", obs, 32'h8000);
    chk("syncwrap_ch3", obs2, 32'h8000);
    ch_run = 0; cyc1;

    // stop on a wrap edge: no tick, busy drops
    wr(0, 3, 0);
    ch_run[0] = 1'b1; cyc1;
    obs = 0;
    for (int k = 1; k <= 8; k++) begin ch_run[0] = (k < 8); cyc1; obs[k-1] = tick_en[0]; end
    chk("stop_ticks", obs, 32'h08);
    chk("stop_busy", 32'(ch_busy[0]), 0);

    // div 0 periodic holds tick high; async reset clears outputs mid-count
    wr(0, 0, 0); wr(1, 9, 0);
    ch_run = 4'b0011; cyc1;
    obs = 0;
    for (int k = 1; k <= 4; k++) begin cyc1; obs[k-1] = tick_en[0]; end
    chk("div0_held", obs, 32'hF);
    chk("busy_pre_rst", 32'(ch_busy), 32'h3);
    reset_in = 1'b1; #2;
    chk("async_rst_tick", 32'(tick_en), 0);
    chk("async_rst_busy", 32'(ch_busy), 0);
    ch_run = 0; cyc1;
    reset_in = 1'b0;
    ch_run = 4'b0011; cyc1;
    obs = 0; obs2 = 0;
    for (int k = 1; k <= 6; k++) begin cyc1; obs[k-1] = tick_en[0]; obs2[k-1] = tick_en[1]; end
    chk("post_rst_ch0", obs, 32'h20);
    chk("post_rst_ch1", obs2, 32'h20);
    ch_run = 0; cyc1;

    // max divisor 255: period 256
    wr(2, 255, 0);
    ch_run[2] = 1'b1; cyc1;
    n = 0; t1 = 0; t2 = 0;
    for (int k = 1; k <= 520; k++) begin
      cyc1;
      if (tick_en[2]) begin
        n++;
        if (n == 1) t1 = k;
        if (n == 2) t2 = k;
      end
    end
    chk("max_first", 32'(t1), 256);
    chk("max_second", 32'(t2), 512);
    chk("max_count", 32'(n), 2);
    ch_run[2] = 1'b0; cyc1;

    // write to out-of-range channel index leaves all channels at RESET_DIV
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd1; cfg_oneshot = 1'b1; cyc1;
    cfg_we3 = 1'b0;
    ch_run3 = 3'b111; cyc1;
    early = 0; last = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc1;
      if (k < 6) early = early | 32'(tick_en3);
      else last = 32'(tick_en3);
    end
    chk("oor_early", early, 0);
    chk("oor_tick6", last, 32'h7);
    ch_run3 = 0; cyc1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
